conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 The block SHALL have these parameters: ACT_W, default 12, activation width; WEIGHT_W, default 12, weight width; CNT_W, default 32, job-length counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  job start pulse
- cfg_mode_1_1  in  1  1 = 1x1 job, 0 = 3-tap job
- cfg_act_count  in  CNT_W  activations in the job
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- w_in_data  in  WEIGHT_W  weight stream data
- w_in_valid  in  1  weight stream valid
- w_in_ready  out  1  weight stream ready
- a_in_data  in  ACT_W  activation stream data
- a_in_valid  in  1  activation stream valid
- a_in_ready  out  1  activation stream ready
- act_data  out  ACT_W  to PE activation input
- act_valid  out  1  to PE activation valid
- mode_1_1  out  1  to PE mode select
- weight_data  out  WEIGHT_W  to PE weight input
- weight_valid  out  1  to PE weight shift-in strobe
- weight_switch  out  1  to PE weight commit strobe
- pe_inter_valid  in  1  from PE result valid

Function
REQ-003 The block SHALL implement the states IDLE, WLOAD, SWITCH, STREAM, DRAIN and DONE.
REQ-004 In IDLE, cfg_start=1 SHALL latch cfg_mode_1_1 and cfg_act_count and move to WLOAD; cfg_start in any other state SHALL be ignored.
REQ-005 busy SHALL be 1 in every state except IDLE.
REQ-006 In WLOAD, w_in_ready SHALL be 1, and each w_in_valid&w_in_ready transfer SHALL register w_in_data onto weight_data and drive weight_valid=1 for the following cycle only.
REQ-007 WLOAD SHALL accept exactly 3 words in a 3-tap job and exactly 1 word in a 1x1 job, then go to SWITCH.
REQ-008 SWITCH SHALL last one cycle and drive weight_switch=1 in a 3-tap job; in a 1x1 job weight_switch SHALL stay 0.
REQ-009 After SWITCH, the block SHALL go to STREAM, or to DONE directly when the latched count is 0.
REQ-010 weight_data SHALL hold its last loaded value until the next WLOAD transfer, because the PE reloads w1 from weight_data on every cycle that mode_1_1=1.
REQ-011 mode_1_1 SHALL drive the latched mode from WLOAD entry onward and hold it after the job until the next start.
REQ-012 In STREAM, a_in_ready SHALL be 1, and each a_in_valid&a_in_ready transfer SHALL register a_in_data onto act_data with act_valid=1 one cycle later; act_valid SHALL be 0 on cycles with no transfer.
REQ-013 act_data SHALL hold its value when act_valid=0.
REQ-014 An accepted-activation counter SHALL increment per transfer; when the count-th transfer is accepted, a_in_ready SHALL drop the next cycle and the state SHALL go to DRAIN.
REQ-015 No transfer beyond the count SHALL ever be accepted.
REQ-016 A result counter SHALL count pe_inter_valid cycles while busy, and pulses outside a job SHALL be ignored.
REQ-017 DRAIN SHALL go to DONE in the cycle after the result count equals the latched count, including a final pulse arriving in the same cycle as the STREAM-to-DRAIN transition.
REQ-018 DONE SHALL last one cycle with done=1, clear both counters and return to IDLE.
REQ-019 w_in_ready SHALL be 0 outside WLOAD, and a_in_ready SHALL be 0 outside STREAM.
REQ-020 Counters SHALL be CNT_W bits wide; cfg_act_count=2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-021 rst_n=0 at any time, including mid-job, SHALL immediately force state IDLE and clear both counters.
REQ-022 rst_n=0 SHALL immediately drive 0 on busy, done, w_in_ready, a_in_ready, act_valid, weight_valid, weight_switch, mode_1_1, act_data and weight_data.
REQ-023 Deassertion of rst_n SHALL take effect at the next clk edge.

Verification
REQ-024 3-tap job with count=4 and weights 1,2,3 always valid -> weight_valid high for 3 single cycles carrying 1,2,3, then weight_switch for 1 cycle, 4 act_valid pulses, done 1 cycle after the 4th pe_inter_valid.
REQ-025 1x1 job with weight 5 and count=2 -> 1 weight_valid, weight_switch never high, mode_1_1=1, weight_data held at 5 through done.
REQ-026 a_in_valid toggling 1,0,1,0 -> act_valid follows one cycle late, act_data holds during gaps, and a 5th presented word is not accepted.
REQ-027 count=0 -> weights loaded, no act_valid, done 1 cycle after SWITCH.
REQ-028 rst_n low during STREAM after 2 of 8 transfers -> all outputs 0 at once, and a new start runs a full job normally.
REQ-029 cfg_start pulsed during DRAIN -> ignored, with exactly one done pulse.

Source files
------------

// File: rtl/conv_ctrl.sv
// ----------------------------------------------------------------------------
// conv_ctrl
// Job sequencer for a convolution PE. A job loads 3 weights (3-tap) or
// 1 weight (1x1) into the PE, commits them, streams a fixed number of
// activations, then waits for the PE to return one result per activation.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_start           job start pulse (honoured only when idle)
//   cfg_mode_1_1        1 = 1x1 job, 0 = 3-tap job
//   cfg_act_count       number of activations in the job
//   busy / done         job in progress / one-cycle completion pulse
//   w_in_*              weight stream (valid/ready)
//   a_in_*              activation stream (valid/ready)
//   act_data/act_valid  activation to PE
//   mode_1_1            mode select to PE
//   weight_data         weight to PE (held between loads)
//   weight_valid        weight shift-in strobe to PE
//   weight_switch       weight commit strobe to PE (3-tap only)
//   pe_inter_valid      result valid from PE
// ----------------------------------------------------------------------------
module conv_ctrl #(
    parameter int unsigned ACT_W    = 12,
    parameter int unsigned WEIGHT_W = 12,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_mode_1_1,
    input  logic [CNT_W-1:0]    cfg_act_count,
    output logic                busy,
    output logic                done,
    input  logic [WEIGHT_W-1:0] w_in_data,
    input  logic                w_in_valid,
    output logic                w_in_ready,
    input  logic [ACT_W-1:0]    a_in_data,
    input  logic                a_in_valid,
    output logic                a_in_ready,
    output logic [ACT_W-1:0]    act_data,
    output logic                act_valid,
    output logic                mode_1_1,
    output logic [WEIGHT_W-1:0] weight_data,
    output logic                weight_valid,
    output logic                weight_switch,
    input  logic                pe_inter_valid
);

    localparam int unsigned WCNT_W = 2;
    localparam int unsigned RES_W  = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WLOAD  = 3'd1,
        S_SWITCH = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_mode;
    logic [CNT_W-1:0]    r_count;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]    r_act_cnt;
    logic [CNT_W-1:0]    r_res_cnt;

    logic                r_busy;
    logic                r_done;
    logic                r_w_in_ready;
    logic                r_a_in_ready;
    logic                r_weight_switch;
    logic                r_weight_valid;
    logic [WEIGHT_W-1:0] r_weight_data;
    logic                r_act_valid;
    logic [ACT_W-1:0]    r_act_data;

    logic                w_start;
    logic                w_w_xfer;
    logic                w_a_xfer;
    logic [WCNT_W-1:0]   w_wneed;
    logic [WCNT_W-1:0]   w_wcnt_inc;
    logic                w_w_last;
    logic                w_wload_full;
    logic [CNT_W-1:0]    w_act_inc;
    logic                w_a_last;
    logic                w_res_evt;
    logic [RES_W-1:0]    w_res_sum;
    logic                w_res_met;

    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_w_ready_nxt;
    logic                w_a_ready_nxt;
    logic                w_switch_nxt;

    // Handshake and counter decode
    assign w_start      = (r_state == S_IDLE) && cfg_start;
    assign w_w_xfer     = w_in_valid && r_w_in_ready;
    assign w_a_xfer     = a_in_valid && r_a_in_ready;
    assign w_wneed      = r_mode ? WCNT_W'(1) : WCNT_W'(3);
    assign w_wcnt_inc   = r_wcnt + WCNT_W'(1);
    assign w_w_last     = w_w_xfer && (w_wcnt_inc == w_wneed);
    assign w_wload_full = (r_wcnt == w_wneed);
    assign w_act_inc    = r_act_cnt + CNT_W'(1);
    assign w_a_last     = w_a_xfer && (w_act_inc == r_count);

    // Result count including this cycle's pulse; one extra bit so an
    // all-ones job length can be reached without wrapping.
    assign w_res_evt    = pe_inter_valid && (r_state != S_IDLE);
    assign w_res_sum    = {1'b0, r_res_cnt} + RES_W'(w_res_evt);
    assign w_res_met    = (w_res_sum >= {1'b0, r_count});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_next_state = S_WLOAD;
                end
            end
            // Leave one cycle after the final word so the commit strobe
            // always trails the last shift-in strobe.
            S_WLOAD: begin
                if (w_wload_full) begin
                    w_next_state = S_SWITCH;
                end
            end
            S_SWITCH: begin
                if (r_count == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_a_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_res_met) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they belong to.
    always_comb begin
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_w_ready_nxt = 1'b0;
        w_a_ready_nxt = 1'b0;
        w_switch_nxt  = 1'b0;
        case (w_next_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            S_WLOAD: begin
                w_busy_nxt    = 1'b1;
                w_w_ready_nxt = !w_w_last;
            end
            S_SWITCH: begin
                w_busy_nxt   = 1'b1;
                w_switch_nxt = !r_mode;
            end
            S_STREAM: begin
                w_busy_nxt    = 1'b1;
                w_a_ready_nxt = 1'b1;
            end
            S_DRAIN: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_w_in_ready    <= 1'b0;
            r_a_in_ready    <= 1'b0;
            r_weight_switch <= 1'b0;
        end else begin
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            r_w_in_ready    <= w_w_ready_nxt;
            r_a_in_ready    <= w_a_ready_nxt;
            r_weight_switch <= w_switch_nxt;
        end
    end

    // Job configuration and counters; DONE clears all counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= 1'b0;
            r_count   <= '0;
            r_wcnt    <= '0;
            r_act_cnt <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_start) begin
                r_mode  <= cfg_mode_1_1;
                r_count <= cfg_act_count;
            end
            if (r_state == S_DONE) begin
                r_wcnt    <= '0;
                r_act_cnt <= '0;
                r_res_cnt <= '0;
            end else begin
                if (w_w_xfer) begin
                    r_wcnt <= w_wcnt_inc;
                end
                if (w_a_xfer) begin
                    r_act_cnt <= w_act_inc;
                end
                if (w_res_evt && !w_res_sum[RES_W-1]) begin
                    r_res_cnt <= w_res_sum[CNT_W-1:0];
                end
            end
        end
    end

    // Weight and activation datapath; data registers hold between transfers
    // because the PE keeps re-reading weight_data in 1x1 mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight_valid <= 1'b0;
            r_weight_data  <= '0;
            r_act_valid    <= 1'b0;
            r_act_data     <= '0;
        end else begin
            r_weight_valid <= w_w_xfer;
            if (w_w_xfer) begin
                r_weight_data <= w_in_data;
            end
            r_act_valid <= w_a_xfer;
            if (w_a_xfer) begin
                r_act_data <= a_in_data;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign w_in_ready    = r_w_in_ready;
    assign a_in_ready    = r_a_in_ready;
    assign weight_switch = r_weight_switch;
    assign weight_valid  = r_weight_valid;
    assign weight_data   = r_weight_data;
    assign act_valid     = r_act_valid;
    assign act_data      = r_act_data;
    assign mode_1_1      = r_mode;

endmodule

// File: tb/tb_conv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_conv_ctrl
// Randomized job-level bench for conv_ctrl with a small PE model that returns
// one result per activation after a programmable latency.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_ctrl;

    localparam int unsigned ACT_W    = 12;
    localparam int unsigned WEIGHT_W = 12;
    localparam int unsigned CW       = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_start;
    logic                cfg_mode_1_1;
    logic [CW-1:0]       cfg_act_count;
    logic                busy;
    logic                done;
    logic [WEIGHT_W-1:0] w_in_data;
    logic                w_in_valid;
    logic                w_in_ready;
    logic [ACT_W-1:0]    a_in_data;
    logic                a_in_valid;
    logic                a_in_ready;
    logic [ACT_W-1:0]    act_data;
    logic                act_valid;
    logic                mode_1_1;
    logic [WEIGHT_W-1:0] weight_data;
    logic                weight_valid;
    logic                weight_switch;
    logic                pe_inter_valid;

    int n_checks = 0;
    int n_fail   = 0;

    conv_ctrl #(
        .ACT_W    (ACT_W),
        .WEIGHT_W (WEIGHT_W),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_mode_1_1   (cfg_mode_1_1),
        .cfg_act_count  (cfg_act_count),
        .busy           (busy),
        .done           (done),
        .w_in_data      (w_in_data),
        .w_in_valid     (w_in_valid),
        .w_in_ready     (w_in_ready),
        .a_in_data      (a_in_data),
        .a_in_valid     (a_in_valid),
        .a_in_ready     (a_in_ready),
        .act_data       (act_data),
        .act_valid      (act_valid),
        .mode_1_1       (mode_1_1),
        .weight_data    (weight_data),
        .weight_valid   (weight_valid),
        .weight_switch  (weight_switch),
        .pe_inter_valid (pe_inter_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One complete job. The expected behaviour is expressed as job-level
    // facts: which words must come out, how many strobes, and when done fires
    // relative to the PE's last result.
    task automatic run_job(input bit mode, input int cnt, input int w_pct,
                           input bit a_toggle, input int a_pct, input int pe_lat,
                           input bit drain_start, input int abort_at, input int extra);
        logic [WEIGHT_W-1:0] wq[$];
        logic [ACT_W-1:0]    aq[$];
        logic [WEIGHT_W-1:0] obs_w[$];
        logic [ACT_W-1:0]    obs_a[$];
        logic [ACT_W-1:0]    acc_a[$];
        int                  pe_due[$];
        int                  nw;
        int                  wi;
        int                  ai;
        int                  done_cnt;
        int                  done_cyc;
        int                  sw_cnt;
        int                  sw_cyc;
        int                  last_wv;
        int                  last_pe;
        int                  pe_sent;
        int                  last_wx;
        int                  last_ax;
        int                  budget;
        bit                  drain_pulsed;
        bit                  have_act;
        bit                  a_tog;
        logic [ACT_W-1:0]    last_act;

        nw = mode ? 1 : 3;
        wi = 0; ai = 0; done_cnt = 0; done_cyc = -1; sw_cnt = 0; sw_cyc = -1;
        last_wv = -1; last_pe = -1; pe_sent = 0; last_wx = -1; last_ax = -1;
        drain_pulsed = 1'b0; have_act = 1'b0; a_tog = 1'b0; last_act = '0;
        for (int i = 0; i < nw + 1; i++) wq.push_back(WEIGHT_W'($urandom));
        for (int i = 0; i < cnt + extra; i++) aq.push_back(ACT_W'($urandom));
        budget = 200 + 4 * cnt + 4 * pe_lat;

        // stray PE results while idle must not count toward the job
        @(negedge clk);
        pe_inter_valid = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'(0));
        pe_inter_valid = 1'b0;
        cfg_start      = 1'b1;
        cfg_mode_1_1   = mode;
        cfg_act_count  = CW'(cnt);

        for (int c = 1; c < budget; c++) begin
            @(negedge clk);
            cfg_start = 1'b0;

            if (abort_at >= 0 && acc_a.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_ctrl_outs",
                         64'({busy, done, w_in_ready, a_in_ready, act_valid,
                              weight_valid, weight_switch, mode_1_1}), 64'(0));
                check_eq("abort_data_outs", 64'({act_data, weight_data}), 64'(0));
                w_in_valid     = 1'b0;
                a_in_valid     = 1'b0;
                pe_inter_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_eq("abort_idle_after", 64'(busy), 64'(0));
                return;
            end

            // observe this cycle
            check_eq("busy", 64'(busy), 64'(done_cyc < 0));
            check_eq("mode_1_1", 64'(mode_1_1), 64'(mode));
            check_eq("ready_overlap", 64'(w_in_ready & a_in_ready), 64'(0));
            if (wi >= nw) check_eq("w_ready_after_load", 64'(w_in_ready), 64'(0));
            if (acc_a.size() >= cnt) check_eq("a_ready_after_count", 64'(a_in_ready), 64'(0));
            if (weight_valid) begin
                check_eq("wv_latency", 64'(last_wx), 64'(c - 1));
                obs_w.push_back(weight_data);
                last_wv = c;
            end else if (obs_w.size() > 0) begin
                check_eq("w_hold", 64'(weight_data), 64'(obs_w[$]));
            end
            if (weight_switch) begin
                sw_cnt++;
                sw_cyc = c;
            end
            if (act_valid) begin
                check_eq("av_latency", 64'(last_ax), 64'(c - 1));
                obs_a.push_back(act_data);
                pe_due.push_back(c + pe_lat);
                last_act = act_data;
                have_act = 1'b1;
            end else if (have_act) begin
                check_eq("act_hold", 64'(act_data), 64'(last_act));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end

            // drive for the coming edge
            pe_inter_valid = 1'b0;
            if (pe_due.size() > 0 && pe_due[0] == c) begin
                void'(pe_due.pop_front());
                pe_inter_valid = 1'b1;
                pe_sent++;
                last_pe = c;
            end
            w_in_valid = (wi < wq.size()) && (int'($urandom_range(99)) < w_pct);
            w_in_data  = (wi < wq.size()) ? wq[wi] : WEIGHT_W'($urandom);
            if (w_in_valid && w_in_ready) begin
                wi++;
                last_wx = c;
            end
            a_tog      = ~a_tog;
            a_in_valid = (ai < aq.size()) &&
                         (a_toggle ? a_tog : (int'($urandom_range(99)) < a_pct));
            a_in_data  = (ai < aq.size()) ? aq[ai] : ACT_W'($urandom);
            if (a_in_valid && a_in_ready) begin
                acc_a.push_back(aq[ai]);
                ai++;
                last_ax = c;
            end
            if (drain_start && !drain_pulsed && cnt > 0 && obs_a.size() == cnt && done_cyc < 0) begin
                cfg_start    = 1'b1;
                cfg_mode_1_1 = ~mode;
                drain_pulsed = 1'b1;
            end

            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end

        w_in_valid     = 1'b0;
        a_in_valid     = 1'b0;
        pe_inter_valid = 1'b0;
        cfg_start      = 1'b0;

        check_eq("done_seen", 64'(done_cyc >= 0), 64'(1));
        check_eq("done_pulses", 64'(done_cnt), 64'(1));
        check_eq("w_count", 64'(obs_w.size()), 64'(nw));
        for (int i = 0; i < nw && i < obs_w.size(); i++)
            check_eq("w_data", 64'(obs_w[i]), 64'(wq[i]));
        check_eq("switch_pulses", 64'(sw_cnt), 64'(mode ? 0 : 1));
        if (!mode && sw_cyc >= 0)
            check_eq("switch_after_w", 64'(sw_cyc > last_wv), 64'(1));
        check_eq("acc_count", 64'(acc_a.size()), 64'(cnt));
        check_eq("act_count", 64'(obs_a.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < obs_a.size() && i < acc_a.size(); i++)
            check_eq("act_data", 64'(obs_a[i]), 64'(acc_a[i]));
        if (cnt == 0 && !mode)
            check_eq("done_after_switch", 64'(done_cyc), 64'(sw_cyc + 1));
        if (cnt > 0) begin
            check_eq("pe_sent", 64'(pe_sent), 64'(cnt));
            check_eq("done_after_pe", 64'(done_cyc), 64'(last_pe + 1));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_mode_1_1   = 1'b0;
        cfg_act_count  = '0;
        w_in_data      = '0;
        w_in_valid     = 1'b0;
        a_in_data      = '0;
        a_in_valid     = 1'b0;
        pe_inter_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_ctrl_outs",
                 64'({busy, done, w_in_ready, a_in_ready, act_valid,
                      weight_valid, weight_switch, mode_1_1}), 64'(0));
        check_eq("reset_data_outs", 64'({act_data, weight_data}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_busy", 64'(busy), 64'(0));

        // 3-tap, count 4, everything always valid
        run_job(1'b0, 4, 100, 1'b0, 100, 2, 1'b0, -1, 0);
        // 1x1, count 2
        run_job(1'b1, 2, 100, 1'b0, 100, 1, 1'b0, -1, 0);
        // toggling activation valid with one extra word offered
        run_job(1'b0, 4, 100, 1'b1, 0, 1, 1'b0, -1, 1);
        // empty jobs in both modes
        run_job(1'b0, 0, 100, 1'b0, 100, 0, 1'b0, -1, 2);
        run_job(1'b1, 0, 70, 1'b0, 100, 0, 1'b0, -1, 0);
        // reset mid-stream after 2 of 8, then a full job
        run_job(1'b0, 8, 100, 1'b0, 100, 2, 1'b0, 2, 0);
        run_job(1'b0, 8, 100, 1'b0, 100, 2, 1'b0, -1, 0);
        // start pulse while draining
        run_job(1'b0, 5, 100, 1'b0, 100, 4, 1'b1, -1, 0);
        // final result in the same cycle as the last activation
        run_job(1'b1, 3, 100, 1'b0, 100, 0, 1'b0, -1, 1);
        // largest job length for the counter width
        run_job(1'b0, 255, 80, 1'b0, 70, 1, 1'b0, -1, 2);

        for (int j = 0; j < 8; j++) begin
            run_job(1'($urandom_range(1)), int'($urandom_range(12)),
                    int'($urandom_range(100, 40)), 1'b0,
                    int'($urandom_range(100, 30)), int'($urandom_range(5)),
                    1'b0, -1, int'($urandom_range(2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
